// File: rtl/cdb_pkg.sv
// Shared types and defaults for the common-data-bus arbiter.
// Optional feature macro: CDB_RR_EN (round-robin tie-break instead of fixed priority).
package cdb_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cdb_trb_t;

    typedef struct packed {
        cdb_trb_t trb;
        logic     exc;
    } cdb_entry_t;

    typedef enum logic {
        SRC_ADD = 1'b0,
        SRC_MUL = 1'b1
    } cdb_src_e;

    // The source that was not granted last; used to alternate on ties.
    function automatic cdb_src_e other_src(input cdb_src_e s);
        return (s == SRC_ADD) ? SRC_MUL : SRC_ADD;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Synchronous FIFO with wrap-bit pointers, flush and a combinational head output.
module cdb_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Status flags and next pointers; flush wins over any push or pop.
    always_comb begin
        full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
        dout = mem[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two source FIFOs feeding one registered broadcast bus.
// Optional feature macro: CDB_RR_EN selects round-robin on ties; otherwise the
// multiplier has fixed priority over the adder.
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = cdb_pkg::TAG_W,
    parameter int DATA_W     = cdb_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    add_valid,
    output logic                    add_ready,
    input  logic [TAG_W+DATA_W-1:0] add_trb,
    input  logic                    add_exc,
    input  logic                    mul_valid,
    output logic                    mul_ready,
    input  logic [TAG_W+DATA_W-1:0] mul_trb,
    input  logic                    mul_exc,
    input  logic                    cdb_stall,
    output logic                    cdb_valid,
    output logic [TAG_W+DATA_W-1:0] cdb_trb,
    output logic                    cdb_exc,
    output logic                    cdb_src
);

    import cdb_pkg::*;

    localparam int TW = TAG_W + DATA_W;
    localparam int EW = TW + 1;

    logic [EW-1:0] add_head, mul_head, sel_head;
    logic          add_full, add_empty, mul_full, mul_empty;
    logic          add_push, mul_push, add_pop, mul_pop;
    logic          grant_any;
    cdb_src_e      grant_src, tie_src;

    logic          cdb_valid_q, cdb_valid_d;
    logic [TW-1:0] cdb_trb_q, cdb_trb_d;
    logic          cdb_exc_q, cdb_exc_d;
    cdb_src_e      cdb_src_q, cdb_src_d;

`ifdef CDB_RR_EN
    cdb_src_e      last_q, last_d;

    // Tie goes to whichever source was not granted most recently.
    always_comb begin
        tie_src = other_src(last_q);
        last_d  = grant_any ? grant_src : last_q;
    end

    // Last-grant register; only moves on a real grant.
    always_ff @(posedge clk) begin
        if (!rst) last_q <= SRC_ADD;
        else      last_q <= last_d;
    end
`else
    // Fixed priority: the multiplier always wins a tie.
    always_comb begin
        tie_src = SRC_MUL;
    end
`endif

    // Handshake and push qualification; tag 0 is accepted but never stored.
    always_comb begin
        add_ready = rst && !add_full;
        mul_ready = rst && !mul_full;
        add_push  = add_valid && add_ready && (add_trb[TW-1 -: TAG_W] != '0);
        mul_push  = mul_valid && mul_ready && (mul_trb[TW-1 -: TAG_W] != '0);
    end

    // Grant selection and output register next state.
    always_comb begin
        grant_any = !cdb_stall && !flush && (!add_empty || !mul_empty);
        if (!add_empty && !mul_empty) grant_src = tie_src;
        else if (!mul_empty)          grant_src = SRC_MUL;
        else                          grant_src = SRC_ADD;
        add_pop  = grant_any && (grant_src == SRC_ADD);
        mul_pop  = grant_any && (grant_src == SRC_MUL);
        sel_head = (grant_src == SRC_MUL) ? mul_head : add_head;

        cdb_valid_d = cdb_valid_q;
        cdb_trb_d   = cdb_trb_q;
        cdb_exc_d   = cdb_exc_q;
        cdb_src_d   = cdb_src_q;
        if (flush) begin
            cdb_valid_d = 1'b0;
        end else if (!cdb_stall) begin
            cdb_valid_d = grant_any;
            if (grant_any) begin
                cdb_trb_d = sel_head[EW-1:1];
                cdb_exc_d = sel_head[0];
                cdb_src_d = grant_src;
            end
        end
    end

    // Broadcast output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_valid_q <= 1'b0;
            cdb_trb_q   <= '0;
            cdb_exc_q   <= 1'b0;
            cdb_src_q   <= SRC_ADD;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_trb_q   <= cdb_trb_d;
            cdb_exc_q   <= cdb_exc_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_trb   = cdb_trb_q;
    assign cdb_exc   = cdb_exc_q;
    assign cdb_src   = cdb_src_q;

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_add_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (add_push),
        .pop   (add_pop),
        .din   ({add_trb, add_exc}),
        .dout  (add_head),
        .full  (add_full),
        .empty (add_empty)
    );

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_mul_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (mul_push),
        .pop   (mul_pop),
        .din   ({mul_trb, mul_exc}),
        .dout  (mul_head),
        .full  (mul_full),
        .empty (mul_empty)
    );

endmodule
